iq_age_scheduler: RTL and testbench
===================================

// Module: iq_age_scheduler
// PURPOSE
//  Oldest-first scheduler for a circular issue queue of DEPTH slots. Allocates entries at tail, selects the
//  oldest valid+ready entry relative to head each cycle and hands it to one FU via valid/ready, then retires
//  freed slots from head. Sits between rename/dispatch (alloc side) and the FU issue port; wakeup logic
//  outside this block drives entry_ready. Uses precoder to rotate the candidate vector so bit 0 = head.
// PARAMETERS
//  WIDTH  5           slot index width
//  DEPTH  1<<WIDTH    slot count; must equal 1<<WIDTH (pointers wrap naturally)
//  TAGW   6           destination tag width stored per slot
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  flush        in   1      discard all entries (mispredict/exception)
//  alloc_valid  in   1      dispatch offers an entry
//  alloc_tag    in   TAGW   tag of offered entry
//  alloc_ready  out  1      slot available (= !full)
//  alloc_idx    out  WIDTH  slot the offered entry lands in (= tail)
//  entry_ready  in   DEPTH  per-slot operands-ready from wakeup logic
//  issue_valid  out  1      a valid+ready entry is selected
//  issue_idx    out  WIDTH  selected slot
//  issue_tag    out  TAGW   tag of selected slot
//  issue_ready  in   1      FU accepts this cycle
//  head_o       out  WIDTH  oldest slot pointer
//  span_o       out  WIDTH+1  slots between head and tail, holes included
//  full         out  1      span_o == DEPTH
//  empty        out  1      span_o == 0
// BEHAVIOUR
//  - State: valid[DEPTH], tag[DEPTH], head, tail (WIDTH, wrap mod DEPTH), span (WIDTH+1).
//  - Reset: valid=0, head=tail=0, span=0 -> alloc_ready=1, alloc_idx=0, issue_valid=0, issue_idx=0,
//    issue_tag=0, empty=1, full=0. Tag RAM contents not reset.
//  - Alloc fires on alloc_valid & alloc_ready: valid[tail]<=1, tag[tail]<=alloc_tag, tail<=tail+1.
//    alloc_ready depends on registered span only; no same-cycle bypass of a head retirement.
//  - Select (combinational from state + entry_ready, 0-cycle): cand = valid & entry_ready; rot =
//    precoder(head, cand); k = lowest set bit of rot; issue_idx = head+k mod DEPTH; issue_valid = |cand & !flush.
//    When issue_valid=0, issue_idx/issue_tag are 0. entry_ready bits of invalid slots are ignored.
//  - Issue fires on issue_valid & issue_ready: valid[issue_idx]<=0 at the edge. Without fire the selection
//    is recomputed each cycle (may change if entry_ready changes; FU must sample only on fire).
//  - Retire: at most one slot per cycle. If span>0 and head slot is free after this cycle's issue
//    (valid[head]==0, or head is being issued now), head<=head+1.
//  - span_next = span + alloc_fire - retire; simultaneous alloc and retire leaves span unchanged.
//  - Holes: slots issued out of order stay counted in span until head walks past them.
//  - Flush: priority over alloc, issue and retire; next cycle valid=0, head=tail=0, span=0.
//    alloc_ready is still driven from span during the flush cycle, but nothing is written.
//  - reset mid-operation behaves identically to flush plus output zeroing.
// STRUCTURE
//  - Shared package iq_pkg: IQ_WIDTH, IQ_DEPTH, IQ_TAGW constants; iq_tag_t, iq_idx_t typedefs.
//  - Sub-modules: existing precoder (WIDTH passed through) for rotation; one new sub-module
//    lsb_prio_enc (DEPTH -> WIDTH index + any-bit). Pointer/span registers and tag RAM stay inline.
// TESTING
//  1 Reset, alloc tags 0x11,0x12,0x13 over 3 cycles, entry_ready=0 -> issue_valid=0, span_o=3, alloc_idx=3.
//  2 Then entry_ready=0b0110, issue_ready=1 -> issue_idx=1/tag 0x12, next cycle idx=2/tag 0x13; head_o stays 0;
//    set bit0 -> idx=0 issues, then head_o steps 1,2,3 on successive cycles, empty=1 after.
//  3 Wrap: head=30, slots 30,31,0 valid, entry_ready bits {0,31} -> issue_idx=31 (older beats index 0).
//  4 Fill 32 entries -> full=1, alloc_ready=0; 33rd alloc_valid ignored (tail unchanged); issue slot head
//    -> head advances next edge, alloc_ready=1 the cycle after, alloc_idx=old head.
//  5 flush in same cycle as alloc_valid and issue fire -> next cycle empty=1, head_o=0, alloc_idx=0, no write.
//  6 issue_ready=0 for 4 cycles with stable entry_ready -> issue_idx/issue_tag stable, valid not cleared.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared issue-queue sizing constants and typedefs for the scheduler slice.
package iq_pkg;
  localparam int IQ_WIDTH = 5;
  localparam int IQ_DEPTH = 1 << IQ_WIDTH;
  localparam int IQ_TAGW  = 6;

  typedef logic [IQ_TAGW-1:0]  iq_tag_t;
  typedef logic [IQ_WIDTH-1:0] iq_idx_t;
endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the first set bit plus an any-bit flag.
module lsb_prio_enc #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 5
) (
  input  logic [DEPTH-1:0] vec,
  output logic [WIDTH-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = WIDTH'(i);
    end
  end
endmodule

// File: rtl/precoder.sv
// Rotates a slot vector right by base so that bit 0 of rot corresponds to slot base.
module precoder #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0]      base,
  input  logic [(1<<WIDTH)-1:0] vec,
  output logic [(1<<WIDTH)-1:0] rot
);
  localparam int DEPTH = 1 << WIDTH;

  logic [2*DEPTH-1:0] dbl;

  assign dbl = {vec, vec} >> base;
  assign rot = dbl[DEPTH-1:0];
endmodule

// File: rtl/iq_age_scheduler.sv
// Oldest-first issue scheduler over a circular issue queue; head-relative selection,
// single-FU valid/ready issue, in-order retirement of freed slots from head.
module iq_age_scheduler
  import iq_pkg::*;
#(
  parameter int WIDTH = IQ_WIDTH,
  parameter int DEPTH = 1 << WIDTH,
  parameter int TAGW  = IQ_TAGW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [TAGW-1:0]  alloc_tag,
  output logic             alloc_ready,
  output logic [WIDTH-1:0] alloc_idx,
  input  logic [DEPTH-1:0] entry_ready,
  output logic             issue_valid,
  output logic [WIDTH-1:0] issue_idx,
  output logic [TAGW-1:0]  issue_tag,
  input  logic             issue_ready,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH:0]   span_o,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0] valid_q;
  logic [TAGW-1:0]  tag_q [DEPTH];
  logic [WIDTH-1:0] head_q, tail_q;
  logic [WIDTH:0]   span_q;

  logic [DEPTH-1:0] cand, rot;
  logic [WIDTH-1:0] k, sel_idx;
  logic             any_cand, alloc_fire, issue_fire, head_free, retire, clear;

  assign full        = (span_q == (WIDTH+1)'(DEPTH));
  assign empty       = (span_q == '0);
  assign alloc_ready = ~full;
  assign alloc_idx   = tail_q;
  assign head_o      = head_q;
  assign span_o      = span_q;

  assign cand = valid_q & entry_ready;

  precoder #(.WIDTH(WIDTH)) u_precoder (
    .base (head_q),
    .vec  (cand),
    .rot  (rot)
  );

  lsb_prio_enc #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_lsb_prio_enc (
    .vec  (rot),
    .idx  (k),
    .any  (any_cand)
  );

  // k is head-relative; adding head back wraps naturally at DEPTH = 2**WIDTH.
  assign sel_idx     = head_q + k;
  assign clear       = reset | flush;
  assign issue_valid = any_cand & ~clear;
  assign issue_idx   = issue_valid ? sel_idx : '0;
  assign issue_tag   = issue_valid ? tag_q[sel_idx] : '0;

  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & issue_ready;
  assign head_free   = ~valid_q[head_q] | (issue_fire & (sel_idx == head_q));
  assign retire      = ~empty & head_free;

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      span_q  <= '0;
    end else begin
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (issue_fire) valid_q[sel_idx] <= 1'b0;
      if (retire) head_q <= head_q + 1'b1;
      span_q <= span_q + (WIDTH+1)'(alloc_fire) - (WIDTH+1)'(retire);
    end
  end

  // Tag RAM holds data only and is never cleared; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (alloc_fire && !clear) tag_q[tail_q] <= alloc_tag;
  end
endmodule

// File: tb/tb_iq_age_scheduler.sv
// Randomized and directed bench for iq_age_scheduler against a slot-array reference model.
module tb_iq_age_scheduler;
  import iq_pkg::*;

  localparam int W = IQ_WIDTH;
  localparam int D = IQ_DEPTH;

  logic          clk = 1'b0;
  logic          reset, flush, alloc_valid, issue_ready;
  iq_tag_t       alloc_tag, issue_tag;
  logic          alloc_ready, issue_valid, full, empty;
  iq_idx_t       alloc_idx, issue_idx, head_o;
  logic [W:0]    span_o;
  logic [D-1:0]  entry_ready;

  int n_vec = 0;
  int n_err = 0;

  bit      m_valid [D];
  iq_tag_t m_tag   [D];
  int      m_head, m_tail, m_span;

  always #5 clk = ~clk;

  iq_age_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .entry_ready (entry_ready),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .head_o      (head_o),
    .span_o      (span_o),
    .full        (full),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_valid[i] = 0;
    m_head = 0;
    m_tail = 0;
    m_span = 0;
  endtask

  // One cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input bit av, input iq_tag_t at, input logic [D-1:0] er,
                      input bit ir, input bit fl, input bit rs);
    bit exp_iv, afire, ifire, retire;
    int exp_sel;
    @(negedge clk);
    alloc_valid = av; alloc_tag = at; entry_ready = er;
    issue_ready = ir; flush = fl; reset = rs;
    #1;
    exp_iv = 0; exp_sel = 0;
    for (int k = 0; k < m_span; k++) begin
      int s;
      s = (m_head + k) % D;
      if (m_valid[s] && er[s]) begin
        exp_iv = 1; exp_sel = s;
        break;
      end
    end
    if (fl || rs) begin
      exp_iv = 0; exp_sel = 0;
    end
    check("alloc_ready", alloc_ready, m_span < D);
    check("alloc_idx",   alloc_idx,   m_tail);
    check("issue_valid", issue_valid, exp_iv);
    check("issue_idx",   issue_idx,   exp_sel);
    check("issue_tag",   issue_tag,   exp_iv ? m_tag[exp_sel] : 0);
    check("head_o",      head_o,      m_head);
    check("span_o",      span_o,      m_span);
    check("full",        full,        m_span == D);
    check("empty",       empty,       m_span == 0);
    @(posedge clk);
    if (fl || rs) begin
      model_clear();
    end else begin
      afire = av && (m_span < D);
      ifire = exp_iv && ir;
      if (ifire) m_valid[exp_sel] = 0;
      retire = (m_span > 0) && !m_valid[m_head];
      if (afire) begin
        m_valid[m_tail] = 1;
        m_tag[m_tail]   = at;
        m_tail          = (m_tail + 1) % D;
      end
      if (retire) m_head = (m_head + 1) % D;
      m_span = m_span + int'(afire) - int'(retire);
    end
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; flush = 0; alloc_valid = 0; alloc_tag = 0; entry_ready = '0; issue_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Three allocations with nothing ready, then out-of-order issue and head walk.
    step(1, 6'h11, '0, 0, 0, 0);
    step(1, 6'h12, '0, 0, 0, 0);
    step(1, 6'h13, '0, 0, 0, 0);
    #1;
    check("t1_span", span_o, 3);
    check("t1_alloc_idx", alloc_idx, 3);
    step(0, 0, 32'h6, 1, 0, 0);
    step(0, 0, 32'h6, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h7, 1, 0, 0);
    #1;
    check("t2_empty", empty, 1);

    // Stall: issue_ready low must hold selection and keep the entry valid.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, iq_tag_t'(8 + i), '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h6, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h7, 1, 0, 0);

    // Wrap: walk head to 30, then slots 30,31,0 with ready on 31 and 0.
    do_reset();
    for (int i = 0; i < 30; i++) step(1, iq_tag_t'(i), '1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, iq_tag_t'(6'h20 + i), '0, 0, 0, 0);
    step(0, 0, 32'h8000_0001, 0, 0, 0);
    #1;
    check("t3_head", head_o, 30);
    check("t3_wrap_idx", issue_idx, 31);

    // Fill to full, overflow attempt, then free the head slot.
    do_reset();
    for (int i = 0; i < 33; i++) step(1, iq_tag_t'($urandom), '0, 0, 0, 0);
    #1;
    check("t4_full", full, 1);
    check("t4_tail", alloc_idx, 0);
    step(1, 6'h3f, 32'h1, 1, 0, 0);
    step(1, 6'h2a, '0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);

    // Flush together with alloc and a would-be issue.
    step(1, 6'h15, '1, 1, 1, 0);
    step(0, 0, '0, 0, 0, 0);
    #1;
    check("t5_empty", empty, 1);
    check("t5_head", head_o, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, iq_tag_t'($urandom), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
